memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Parametrised N-channel front end to `memory_unit` that replaces the static, select-driven `memory_mux`. It latches a memory command from any client (MTU, execute, cell, incr, equal, future opcode blocks) and issues it to the single memory port. It tracks each transaction to completion and returns a per-channel done pulse with registered read data. It supports the legacy external-select mode and a round-robin request-arbitration mode.

## Interface
- `N_CH`, 5: number of client channels, 2..16.
- `ADDR_W`, `` `memory_addr_width ``: address width.
- `DATA_W`, `` `memory_data_width ``: data word width.
- `MODE`, 0: 0 = only the channel indexed by `sel` may issue; 1 = round-robin over all pending channels.
- `SEL_W`, `$clog2(N_CH)`: width of `sel` and `grant_id`.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-low reset.
- `sel` in SEL_W: channel select; used only when MODE=0.
- `ch_execute` in N_CH: request strobe, one bit per channel.
- `ch_func` in 2*N_CH: memory function per channel, opaque to the arbiter. Channel i uses bits [2i+1:2i].
- `ch_address1`, `ch_address2` in ADDR_W*N_CH: per-channel addresses.
- `ch_write_data` in DATA_W*N_CH: per-channel write data.
- `ch_done` out N_CH: one-cycle completion pulse to the owning channel.
- `ch_busy` out N_CH: request from this channel is pending or in flight.
- `ch_overflow` out N_CH: sticky; set when a channel strobes while its own request is still pending.
- `rd_data1`, `rd_data2` out DATA_W: read data registered at completion.
- `grant_id` out SEL_W: channel that owns the current or last transaction.
- `mem_func` out 2; `mem_execute` out 1; `mem_address1`, `mem_address2` out ADDR_W; `mem_write_data` out DATA_W: memory command port.
- `mem_ready` in 1; `mem_read_data1`, `mem_read_data2` in DATA_W: memory status and read data.

## Operation
- Per-channel capture: when `ch_execute[i]`=1 at an edge and `ch_busy[i]`=0, capture func, addresses and write data into a per-channel slot, and set `pending[i]`.
  - If `ch_busy[i]`=1 at that edge, the strobe is dropped and `ch_overflow[i]` is set. It clears only on reset.
  - `ch_busy[i]` = `pending[i]` OR (in-flight and `grant_id`=i).
- States:
  - IDLE: choose a winner from `pending`. MODE=0: the winner is `sel` if `pending[sel]`, otherwise none. MODE=1: the first pending channel searching upward from `rr_ptr`, wrapping modulo N_CH. On a winner: load `grant_id`, clear `pending[w]`, go to ISSUE.
  - ISSUE: drive the winner's slot onto `mem_*`, with `mem_execute`=1 for exactly this cycle. Go to WAIT_BUSY.
  - WAIT_BUSY: wait for `mem_ready`=0, then go to WAIT_DONE.
  - WAIT_DONE: on `mem_ready`=1, register `mem_read_data1/2` into `rd_data1/2`, pulse `ch_done[grant_id]`, set `rr_ptr` = (grant_id+1) mod N_CH, and go to IDLE.
- `mem_func`, `mem_address*` and `mem_write_data` hold the granted slot from ISSUE through WAIT_DONE. They hold their last value in IDLE.
- `sel` values ≥ N_CH select no channel.

## Timing
- Reset values: state IDLE; `pending`, `ch_busy`, `ch_done`, `ch_overflow` all 0; `mem_execute` 0; `mem_func`, `mem_address*`, `mem_write_data`, `rd_data*` 0; `grant_id` 0; `rr_ptr` 0.
- Issue latency with an idle arbiter: strobe sampled at edge k, winner registered at edge k+1, `mem_execute` high during cycle k+1..k+2.
- `ch_done` follows the edge at which `mem_ready` is seen high in WAIT_DONE. `rd_data*` is valid in the same cycle and holds until the next completion.
- Minimum turnaround: IDLE → ISSUE → WAIT_BUSY → WAIT_DONE → IDLE, i.e. 4 cycles plus memory latency.
- Back-to-back: a channel may strobe again in the same cycle its `ch_done` is high, because `ch_busy` is already 0.
- Simultaneous strobes from several channels are all captured in the same edge. They are then served in priority order.
- A strobe arriving while the arbiter is in ISSUE or WAIT is captured and waits in `pending`.
- Reset asserted mid-transaction: all state clears immediately and `mem_execute` drops asynchronously. The memory transaction is abandoned, with no `ch_done`.

## Structure
- Shared package/header `memory_arbiter.vh` holds:
  - state encodings ARB_IDLE, ARB_ISSUE, ARB_WAIT_BUSY, ARB_WAIT_DONE;
  - the include of `memory_unit.vh` for default widths.
- One sub-module, `rr_pick`: combinational priority search over `pending` from `rr_ptr`, returning a valid flag and an index. MODE=0 bypasses it.

## Test plan
- MODE=0, N_CH=5, sel=2: ch2 strobes addr1=0x10 → `mem_execute` pulses once with `mem_address1`=0x10; `ch_done`=5'b00100; `rd_data1` equals memory contents.
- MODE=0: ch3 strobes while sel=2 → no issue; sel→3 → issues; `ch_busy[3]` stays high until its done.
- MODE=1: ch0, ch1, ch4 strobe in the same cycle → grant order 0, 1, 4. Then ch0 and ch4 strobe with rr_ptr=2 → order 4, 0.
- Ch1 strobes twice before completion → the second strobe is dropped; `ch_overflow`=5'b00010; exactly one `ch_done[1]` pulse.
- Reset pulled low during WAIT_DONE → every output returns to 0 within the same cycle; after release, a new request completes normally.
- N_CH=8, MODE=1, all channels strobing continuously for 64 transactions → each channel gets 8 grants, and the maximum wait is ≤ 7 transactions.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the memory arbiter and its sub-module.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package memory_arbiter_pkg;

    // Default memory widths, matching the memory_unit port.
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ARB_IDLE      = 2'd0,
        ARB_ISSUE     = 2'd1,
        ARB_WAIT_BUSY = 2'd2,
        ARB_WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/memory_arbiter_rr_pick.sv
// Round-robin search: first set bit of i_pending at or above i_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; o_vld is low when nothing is pending.
module memory_arbiter_rr_pick #(
    parameter int N_CH  = 5,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  i_pending,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_vld,
    output logic [SEL_W-1:0] o_idx
);

    int w_idx;

    // Walk offsets from far to near so the nearest pending channel wins last.
    always_comb begin
        o_vld = 1'b0;
        o_idx = '0;
        w_idx = 0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            w_idx = int'(i_ptr) + k;
            if (w_idx >= N_CH) begin
                w_idx = w_idx - N_CH;
            end
            if (i_pending[w_idx]) begin
                o_vld = 1'b1;
                o_idx = SEL_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// N-channel front end to memory_unit: latches per-channel commands, issues one at a time, returns done + read data.
// Latency: strobe at edge k -> mem_execute during k+1..k+2; ch_done one cycle after mem_ready is seen high in WAIT_DONE.
// Backpressure: ch_busy marks a channel's slot as occupied; strobes while busy are dropped and flagged in ch_overflow.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int N_CH   = 5,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MODE   = 0,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_CH-1:0]        ch_execute,
    input  logic [2*N_CH-1:0]      ch_func,
    input  logic [ADDR_W*N_CH-1:0] ch_address1,
    input  logic [ADDR_W*N_CH-1:0] ch_address2,
    input  logic [DATA_W*N_CH-1:0] ch_write_data,
    output logic [N_CH-1:0]        ch_done,
    output logic [N_CH-1:0]        ch_busy,
    output logic [N_CH-1:0]        ch_overflow,
    output logic [DATA_W-1:0]      rd_data1,
    output logic [DATA_W-1:0]      rd_data2,
    output logic [SEL_W-1:0]       grant_id,
    output logic [1:0]             mem_func,
    output logic                   mem_execute,
    output logic [ADDR_W-1:0]      mem_address1,
    output logic [ADDR_W-1:0]      mem_address2,
    output logic [DATA_W-1:0]      mem_write_data,
    input  logic                   mem_ready,
    input  logic [DATA_W-1:0]      mem_read_data1,
    input  logic [DATA_W-1:0]      mem_read_data2
);

    arb_state_t        r_state, w_next_state;
    logic [N_CH-1:0]   r_pending;
    logic [1:0]        r_slot_func  [N_CH];
    logic [ADDR_W-1:0] r_slot_addr1 [N_CH];
    logic [ADDR_W-1:0] r_slot_addr2 [N_CH];
    logic [DATA_W-1:0] r_slot_wdata [N_CH];
    logic [N_CH-1:0]   r_overflow;
    logic [N_CH-1:0]   r_done;
    logic [SEL_W-1:0]  r_grant;
    logic [SEL_W-1:0]  r_rr_ptr;
    logic [1:0]        r_mem_func;
    logic [ADDR_W-1:0] r_mem_addr1, r_mem_addr2;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rd1, r_rd2;

    logic              w_rr_vld, w_sel_vld, w_win_vld;
    logic [SEL_W-1:0]  w_rr_idx, w_win_idx, w_ptr_next;
    logic              w_load, w_complete;
    logic [N_CH-1:0]   w_grant_oh, w_busy;
    logic [1:0]        w_win_func;
    logic [ADDR_W-1:0] w_win_addr1, w_win_addr2;
    logic [DATA_W-1:0] w_win_wdata;

    memory_arbiter_rr_pick #(.N_CH(N_CH), .SEL_W(SEL_W)) u_rr_pick (
        .i_pending (r_pending),
        .i_ptr     (r_rr_ptr),
        .o_vld     (w_rr_vld),
        .o_idx     (w_rr_idx)
    );

    // External-select candidate; out-of-range sel values match no channel.
    always_comb begin
        w_sel_vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (int'(sel) == i && r_pending[i]) begin
                w_sel_vld = 1'b1;
            end
        end
    end

    assign w_win_vld  = (MODE == 1) ? w_rr_vld : w_sel_vld;
    assign w_win_idx  = (MODE == 1) ? w_rr_idx : sel;
    assign w_ptr_next = (r_grant == SEL_W'(N_CH - 1)) ? '0 : r_grant + 1'b1;

    // Decode the owner one-hot and mux the winner's slot onto a single bus.
    always_comb begin
        w_grant_oh  = '0;
        w_win_func  = '0;
        w_win_addr1 = '0;
        w_win_addr2 = '0;
        w_win_wdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_grant_oh[i] = (r_grant == SEL_W'(i));
            if (w_win_idx == SEL_W'(i)) begin
                w_win_func  = r_slot_func[i];
                w_win_addr1 = r_slot_addr1[i];
                w_win_addr2 = r_slot_addr2[i];
                w_win_wdata = r_slot_wdata[i];
            end
        end
    end

    // A channel stays busy from capture until its transaction completes.
    assign w_busy = r_pending | ((r_state != ARB_IDLE) ? w_grant_oh : '0);

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sequencer next state and one-cycle load/complete strobes.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_win_vld) begin
                    w_load       = 1'b1;
                    w_next_state = ARB_ISSUE;
                end
            end
            ARB_ISSUE:     w_next_state = ARB_WAIT_BUSY;
            ARB_WAIT_BUSY: if (!mem_ready) w_next_state = ARB_WAIT_DONE;
            ARB_WAIT_DONE: begin
                if (mem_ready) begin
                    w_complete   = 1'b1;
                    w_next_state = ARB_IDLE;
                end
            end
            default:       w_next_state = ARB_IDLE;
        endcase
    end

    // Per-channel capture; the winner's pending bit clears as it is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending  <= '0;
            r_overflow <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_slot_func[i]  <= '0;
                r_slot_addr1[i] <= '0;
                r_slot_addr2[i] <= '0;
                r_slot_wdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (ch_execute[i] && w_busy[i]) begin
                    r_overflow[i] <= 1'b1;
                end else if (ch_execute[i]) begin
                    r_pending[i]    <= 1'b1;
                    r_slot_func[i]  <= ch_func[2*i +: 2];
                    r_slot_addr1[i] <= ch_address1[ADDR_W*i +: ADDR_W];
                    r_slot_addr2[i] <= ch_address2[ADDR_W*i +: ADDR_W];
                    r_slot_wdata[i] <= ch_write_data[DATA_W*i +: DATA_W];
                end
                if (w_load && w_win_idx == SEL_W'(i)) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Command port load on grant; read data, done pulse and pointer on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_mem_func  <= '0;
            r_mem_addr1 <= '0;
            r_mem_addr2 <= '0;
            r_mem_wdata <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_done      <= '0;
        end else begin
            r_done <= '0;
            if (w_load) begin
                r_grant     <= w_win_idx;
                r_mem_func  <= w_win_func;
                r_mem_addr1 <= w_win_addr1;
                r_mem_addr2 <= w_win_addr2;
                r_mem_wdata <= w_win_wdata;
            end
            if (w_complete) begin
                r_rd1    <= mem_read_data1;
                r_rd2    <= mem_read_data2;
                r_done   <= w_grant_oh;
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    assign ch_done        = r_done;
    assign ch_busy        = w_busy;
    assign ch_overflow    = r_overflow;
    assign rd_data1       = r_rd1;
    assign rd_data2       = r_rd2;
    assign grant_id       = r_grant;
    assign mem_func       = r_mem_func;
    assign mem_execute    = (r_state == ARB_ISSUE);
    assign mem_address1   = r_mem_addr1;
    assign mem_address2   = r_mem_addr2;
    assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench: instance A (5 ch, select mode) and instance B (8 ch, round-robin).
// Each instance drives a small latency-based memory model.
// Expected issues/completions are queued by the stimulus and popped by per-instance monitors.
module tb_memory_arbiter;

    typedef struct {
        int          ch;
        logic [15:0] a1;
        logic [15:0] a2;
        logic [15:0] wd;
        logic [1:0]  fn;
    } exp_t;

    logic clk;
    int   checks;
    int   failures;

    // ---------------- instance A: N_CH=5, MODE=0 ----------------
    logic        a_rst;
    logic [2:0]  a_sel;
    logic [4:0]  a_exec;
    logic [9:0]  a_func;
    logic [79:0] a_addr1, a_addr2, a_wd;
    logic [4:0]  a_done, a_busy, a_ovf;
    logic [15:0] a_rd1, a_rd2;
    logic [2:0]  a_grant;
    logic [1:0]  a_mfunc;
    logic        a_mexec;
    logic [15:0] a_ma1, a_ma2, a_mwd;
    logic        a_mrdy;
    logic [15:0] a_mrd1, a_mrd2;

    memory_arbiter #(.N_CH(5), .ADDR_W(16), .DATA_W(16), .MODE(0)) dut_a (
        .clk(clk), .rst(a_rst), .sel(a_sel), .ch_execute(a_exec), .ch_func(a_func),
        .ch_address1(a_addr1), .ch_address2(a_addr2), .ch_write_data(a_wd),
        .ch_done(a_done), .ch_busy(a_busy), .ch_overflow(a_ovf),
        .rd_data1(a_rd1), .rd_data2(a_rd2), .grant_id(a_grant),
        .mem_func(a_mfunc), .mem_execute(a_mexec), .mem_address1(a_ma1),
        .mem_address2(a_ma2), .mem_write_data(a_mwd), .mem_ready(a_mrdy),
        .mem_read_data1(a_mrd1), .mem_read_data2(a_mrd2)
    );

    // ---------------- instance B: N_CH=8, MODE=1 ----------------
    logic         b_rst;
    logic [2:0]   b_sel;
    logic [7:0]   b_exec;
    logic [15:0]  b_func;
    logic [127:0] b_addr1, b_addr2, b_wd;
    logic [7:0]   b_done, b_busy, b_ovf;
    logic [15:0]  b_rd1, b_rd2;
    logic [2:0]   b_grant;
    logic [1:0]   b_mfunc;
    logic         b_mexec;
    logic [15:0]  b_ma1, b_ma2, b_mwd;
    logic         b_mrdy;
    logic [15:0]  b_mrd1, b_mrd2;

    memory_arbiter #(.N_CH(8), .ADDR_W(16), .DATA_W(16), .MODE(1)) dut_b (
        .clk(clk), .rst(b_rst), .sel(b_sel), .ch_execute(b_exec), .ch_func(b_func),
        .ch_address1(b_addr1), .ch_address2(b_addr2), .ch_write_data(b_wd),
        .ch_done(b_done), .ch_busy(b_busy), .ch_overflow(b_ovf),
        .rd_data1(b_rd1), .rd_data2(b_rd2), .grant_id(b_grant),
        .mem_func(b_mfunc), .mem_execute(b_mexec), .mem_address1(b_ma1),
        .mem_address2(b_ma2), .mem_write_data(b_mwd), .mem_ready(b_mrdy),
        .mem_read_data1(b_mrd1), .mem_read_data2(b_mrd2)
    );

    exp_t qa_iss[$], qa_done[$], qb_iss[$], qb_done[$];
    int   a_lat, b_lat;
    logic b_fair;
    int   b_cnt[8];
    int   b_last[8];
    int   b_total, b_maxgap;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    function automatic exp_t mk(input int ch, input logic [15:0] a1);
        exp_t e;
        e.ch = ch;
        e.a1 = a1;
        e.a2 = a1 + 16'h0100;
        e.wd = ~a1;
        e.fn = 2'(ch);
        return e;
    endfunction

    task automatic push_a(input int ch, input logic [15:0] a1);
        qa_iss.push_back(mk(ch, a1));
        qa_done.push_back(mk(ch, a1));
    endtask

    task automatic push_b(input int ch, input logic [15:0] a1);
        qb_iss.push_back(mk(ch, a1));
        qb_done.push_back(mk(ch, a1));
    endtask

    task automatic a_set(input int ch, input logic [15:0] a1);
        exp_t e;
        e = mk(ch, a1);
        a_exec[ch]           = 1'b1;
        a_func[2*ch +: 2]    = e.fn;
        a_addr1[16*ch +: 16] = e.a1;
        a_addr2[16*ch +: 16] = e.a2;
        a_wd[16*ch +: 16]    = e.wd;
    endtask

    task automatic b_set(input int ch, input logic [15:0] a1);
        exp_t e;
        e = mk(ch, a1);
        b_exec[ch]           = 1'b1;
        b_func[2*ch +: 2]    = e.fn;
        b_addr1[16*ch +: 16] = e.a1;
        b_addr2[16*ch +: 16] = e.a2;
        b_wd[16*ch +: 16]    = e.wd;
    endtask

    task automatic wait_a_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (a_busy == 5'd0 && qa_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag_fail(name);
    endtask

    task automatic wait_b_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (b_busy == 8'd0 && qb_done.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag_fail(name);
    endtask

    // Memory models: ready drops after an issue, returns high after the latency with data derived from the address.
    initial begin
        logic [15:0] pa1, pa2;
        int cnt;
        cnt = 0; pa1 = '0; pa2 = '0;
        a_mrdy = 1'b1; a_mrd1 = '0; a_mrd2 = '0;
        forever begin
            @(negedge clk);
            if (!a_rst) begin
                cnt = 0;
                a_mrdy = 1'b1;
            end else if (a_mexec) begin
                cnt = a_lat; a_mrdy = 1'b0;
                a_mrd1 = 16'hDEAD; a_mrd2 = 16'hDEAD;
                pa1 = a_ma1; pa2 = a_ma2;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    a_mrdy = 1'b1;
                    a_mrd1 = pa1 ^ 16'h5A5A;
                    a_mrd2 = pa2 + 16'h0101;
                end
            end
        end
    end

    initial begin
        logic [15:0] pa1, pa2;
        int cnt;
        cnt = 0; pa1 = '0; pa2 = '0;
        b_mrdy = 1'b1; b_mrd1 = '0; b_mrd2 = '0;
        forever begin
            @(negedge clk);
            if (!b_rst) begin
                cnt = 0;
                b_mrdy = 1'b1;
            end else if (b_mexec) begin
                cnt = b_lat; b_mrdy = 1'b0;
                b_mrd1 = 16'hDEAD; b_mrd2 = 16'hDEAD;
                pa1 = b_ma1; pa2 = b_ma2;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    b_mrdy = 1'b1;
                    b_mrd1 = pa1 ^ 16'h5A5A;
                    b_mrd2 = pa2 + 16'h0101;
                end
            end
        end
    end

    // Monitor A: compare every issue and every completion against the queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (a_rst) begin
                if (a_mexec) begin
                    if (qa_iss.size() == 0) flag_fail("a_unexpected_issue");
                    else begin
                        e = qa_iss.pop_front();
                        check("a_iss_grant", 32'(a_grant), e.ch);
                        check("a_iss_addr1", 32'(a_ma1), 32'(e.a1));
                        check("a_iss_addr2", 32'(a_ma2), 32'(e.a2));
                        check("a_iss_wdata", 32'(a_mwd), 32'(e.wd));
                        check("a_iss_func", 32'(a_mfunc), 32'(e.fn));
                    end
                end
                if (a_done != 5'd0) begin
                    if (qa_done.size() == 0) flag_fail("a_unexpected_done");
                    else begin
                        e = qa_done.pop_front();
                        check("a_done_vec", 32'(a_done), 32'(1) << e.ch);
                        check("a_done_grant", 32'(a_grant), e.ch);
                        check("a_rd_data1", 32'(a_rd1), 32'(e.a1 ^ 16'h5A5A));
                        check("a_rd_data2", 32'(a_rd2), 32'(e.a2 + 16'h0101));
                        check("a_done_notbusy", 32'(a_busy[e.ch]), 0);
                    end
                end
            end
        end
    end

    // Monitor B: queue comparison normally; grant statistics during the fairness run.
    initial begin
        exp_t e;
        int g;
        forever begin
            @(negedge clk);
            if (b_rst && b_fair) begin
                if (b_mexec && b_total < 64) begin
                    g = int'(b_grant);
                    if (b_last[g] >= 0 && (b_total - b_last[g] - 1) > b_maxgap)
                        b_maxgap = b_total - b_last[g] - 1;
                    b_last[g] = b_total;
                    b_cnt[g]++;
                    b_total++;
                end
            end else if (b_rst) begin
                if (b_mexec) begin
                    if (qb_iss.size() == 0) flag_fail("b_unexpected_issue");
                    else begin
                        e = qb_iss.pop_front();
                        check("b_iss_grant", 32'(b_grant), e.ch);
                        check("b_iss_addr1", 32'(b_ma1), 32'(e.a1));
                        check("b_iss_func", 32'(b_mfunc), 32'(e.fn));
                    end
                end
                if (b_done != 8'd0) begin
                    if (qb_done.size() == 0) flag_fail("b_unexpected_done");
                    else begin
                        e = qb_done.pop_front();
                        check("b_done_vec", 32'(b_done), 32'(1) << e.ch);
                        check("b_rd_data1", 32'(b_rd1), 32'(e.a1 ^ 16'h5A5A));
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        bit seen, drop;
        checks = 0; failures = 0;
        a_lat = 2; b_lat = 2; b_fair = 1'b0;
        b_total = 0; b_maxgap = 0;
        for (int i = 0; i < 8; i++) begin b_cnt[i] = 0; b_last[i] = -1; end
        a_rst = 1'b0; a_sel = '0; a_exec = '0; a_func = '0; a_addr1 = '0; a_addr2 = '0; a_wd = '0;
        b_rst = 1'b0; b_sel = '0; b_exec = '0; b_func = '0; b_addr1 = '0; b_addr2 = '0; b_wd = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("a_rst_busy", 32'(a_busy), 0);
        check("a_rst_done", 32'(a_done), 0);
        check("a_rst_ovf", 32'(a_ovf), 0);
        check("a_rst_mexec", 32'(a_mexec), 0);
        check("a_rst_maddr1", 32'(a_ma1), 0);
        check("a_rst_rd1", 32'(a_rd1), 0);
        check("a_rst_grant", 32'(a_grant), 0);
        check("b_rst_busy", 32'(b_busy), 0);
        a_rst = 1'b1; b_rst = 1'b1;
        @(negedge clk);

        // A: sel=2, ch2 strobes addr 0x10; check issue latency.
        a_sel = 3'd2;
        push_a(2, 16'h0010);
        a_set(2, 16'h0010);
        @(negedge clk);
        a_exec = '0;
        check("a_lat_exec_k", 32'(a_mexec), 0);
        check("a_lat_busy_k", 32'(a_busy), 32'h04);
        @(negedge clk);
        check("a_lat_exec_k1", 32'(a_mexec), 1);
        wait_a_idle("a_t1_timeout");

        // A: ch3 strobes while sel=2 -> held pending until sel moves to 3.
        a_set(3, 16'h0033);
        @(negedge clk);
        a_exec = '0;
        repeat (6) @(negedge clk);
        check("a_sel_block_busy", 32'(a_busy), 32'h08);
        check("a_sel_block_exec", 32'(a_mexec), 0);
        push_a(3, 16'h0033);
        a_sel = 3'd3;
        seen = 1'b0; drop = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (a_done[3]) begin seen = 1'b1; break; end
            if (!a_busy[3]) drop = 1'b1;
        end
        check("a_sel3_done_seen", 32'(seen), 1);
        check("a_busy3_held", 32'(drop), 0);
        wait_a_idle("a_t2_timeout");

        // A: out-of-range select issues nothing.
        a_sel = 3'd6;
        a_set(4, 16'h0044);
        @(negedge clk);
        a_exec = '0;
        repeat (5) @(negedge clk);
        check("a_sel_oob_busy", 32'(a_busy), 32'h10);
        push_a(4, 16'h0044);
        a_sel = 3'd4;
        wait_a_idle("a_t3_timeout");

        // A: ch1 strobes twice before completion -> second dropped, overflow sticky.
        a_sel = 3'd1;
        push_a(1, 16'h0011);
        a_set(1, 16'h0011);
        @(negedge clk);
        a_set(1, 16'h0099);
        @(negedge clk);
        a_exec = '0;
        check("a_ovf_set", 32'(a_ovf), 32'h02);
        wait_a_idle("a_t4_timeout");

        // A: back-to-back strobe in the ch_done cycle is accepted.
        push_a(1, 16'h0021);
        push_a(1, 16'h0022);
        a_set(1, 16'h0021);
        @(negedge clk);
        a_exec = '0;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (a_done[1]) begin seen = 1'b1; break; end
        end
        check("a_b2b_first_done", 32'(seen), 1);
        a_set(1, 16'h0022);
        @(negedge clk);
        a_exec = '0;
        wait_a_idle("a_t5_timeout");
        check("a_ovf_sticky", 32'(a_ovf), 32'h02);

        // A: reset during WAIT_DONE abandons the transaction.
        a_lat = 4;
        a_sel = 3'd0;
        push_a(0, 16'h0040);
        a_set(0, 16'h0040);
        @(negedge clk);
        a_exec = '0;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (a_mexec) begin seen = 1'b1; break; end
        end
        check("a_mid_issue_seen", 32'(seen), 1);
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
        #1;
        check("a_mid_rst_busy", 32'(a_busy), 0);
        check("a_mid_rst_mexec", 32'(a_mexec), 0);
        check("a_mid_rst_maddr1", 32'(a_ma1), 0);
        check("a_mid_rst_rd1", 32'(a_rd1), 0);
        check("a_mid_rst_grant", 32'(a_grant), 0);
        check("a_mid_rst_ovf", 32'(a_ovf), 0);
        check("a_mid_rst_done", 32'(a_done), 0);
        qa_done.delete();
        repeat (2) @(negedge clk);
        a_rst = 1'b1;
        a_lat = 2;
        @(negedge clk);
        push_a(0, 16'h0050);
        a_set(0, 16'h0050);
        @(negedge clk);
        a_exec = '0;
        wait_a_idle("a_t6_timeout");

        // B: simultaneous strobes on ch0, ch1, ch4 -> order 0, 1, 4.
        push_b(0, 16'h0100);
        push_b(1, 16'h0101);
        push_b(4, 16'h0104);
        b_set(0, 16'h0100);
        b_set(1, 16'h0101);
        b_set(4, 16'h0104);
        @(negedge clk);
        b_exec = '0;
        wait_b_idle("b_t1_timeout");

        // B: ch1 alone moves the pointer to 2, then ch0+ch4 -> order 4, 0.
        push_b(1, 16'h0201);
        b_set(1, 16'h0201);
        @(negedge clk);
        b_exec = '0;
        wait_b_idle("b_t2_timeout");
        push_b(4, 16'h0304);
        push_b(0, 16'h0300);
        b_set(0, 16'h0300);
        b_set(4, 16'h0304);
        @(negedge clk);
        b_exec = '0;
        wait_b_idle("b_t3_timeout");

        // B: all eight channels strobe continuously for 64 grants.
        b_fair = 1'b1;
        for (int i = 0; i < 8; i++) b_set(i, 16'(16'h0400 + i));
        seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (b_total >= 64) begin seen = 1'b1; break; end
        end
        check("b_fair_reached_64", 32'(seen), 1);
        b_exec = '0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (b_busy == 8'd0) break;
        end
        check("b_fair_drained", 32'(b_busy), 0);
        b_fair = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("b_fair_cnt%0d", i), 32'(b_cnt[i]), 8);
        check("b_fair_maxwait_le7", 32'(b_maxgap <= 7), 1);

        repeat (3) @(negedge clk);
        check("qa_iss_empty", 32'(qa_iss.size()), 0);
        check("qb_iss_empty", 32'(qb_iss.size()), 0);
        check("qb_done_empty", 32'(qb_done.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
